// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-stage types and defaults.
// Used by the fetch sequencer, its buffer and the core top.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    ERR   = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_STEP_DEF  = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch bundle: imem req/gnt, decode valid/ready, redirect.
// FETCH_MISALIGN_TRAP_EN adds the fetch_misaligned flag.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  modport master (
`ifdef FETCH_MISALIGN_TRAP_EN
    output fetch_misaligned,
`endif
    output imem_req, imem_addr,
    output inst_valid, inst_out, inst_pc,
    output pc_out,
    input  imem_gnt, imem_rdata,
    input  inst_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
`ifdef FETCH_MISALIGN_TRAP_EN
    input  fetch_misaligned,
`endif
    input  imem_req, imem_addr,
    input  inst_valid, inst_out, inst_pc,
    input  pc_out,
    output imem_gnt, imem_rdata,
    output inst_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_inst_buffer.sv
// One-entry instruction holding register for decode.
// Flush beats load, load beats consume.
module fetch_inst_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic [31:0] pc_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);
  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] pc_q;

  // Capture granted word; drop it on flush or consume.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      inst_q  <= 32'h0;
      pc_q    <= 32'h0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      inst_q  <= data_i;
      pc_q    <= pc_i;
    end else if (ready_i && valid_q) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and fetch loop: IDLE -> REQ -> VALID -> REQ.
// FETCH_MISALIGN_TRAP_EN traps misaligned redirects in ERR.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);
  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         req_q;
  logic [31:0]  tgt_pc;
  logic         tgt_bad;
  logic         load;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic         mis_q;
`endif

  // Redirect target: raw when trapping, else word aligned.
  always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
    tgt_pc  = bus.redirect_pc;
    tgt_bad = |bus.redirect_pc[1:0];
`else
    tgt_pc  = align_pc(bus.redirect_pc);
    tgt_bad = 1'b0;
`endif
  end

  assign load = req_q && bus.imem_gnt
                && !bus.redirect_valid;

  // Fetch FSM with registered request and PC.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else if (bus.redirect_valid) begin
      pc_q <= tgt_pc;
      if (tgt_bad) begin
        state_q <= ERR;
        req_q   <= 1'b0;
      end else begin
        state_q <= REQ;
        req_q   <= 1'b1;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q <= tgt_bad;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (bus.imem_gnt) begin
            pc_q    <= pc_q + 32'(PC_STEP);
            state_q <= VALID;
            req_q   <= 1'b0;
          end
        end
        VALID: begin
          if (bus.inst_ready) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        ERR: begin
          req_q <= 1'b0;
        end
`else
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
`endif
      endcase
    end
  end

  fetch_inst_buffer u_buf (
    .clk     (clk),
    .reset   (reset),
    .flush_i (bus.redirect_valid),
    .load_i  (load),
    .data_i  (bus.imem_rdata),
    .pc_i    (pc_q),
    .ready_i (bus.inst_ready),
    .valid_o (bus.inst_valid),
    .inst_o  (bus.inst_out),
    .pc_o    (bus.inst_pc)
  );

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.pc_out    = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.fetch_misaligned = mis_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector bench for fetch_sequencer.
// Inputs set on negedge, registered outputs checked 1ns later.
module tb_fetch_sequencer;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fetch_sequencer_if bus();

  fetch_sequencer #(
    .RESET_PC (32'h0),
    .PC_STEP  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  typedef struct packed {
    logic        chk;
    logic        rst;
    logic        gnt;
    logic [31:0] rdata;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] pc;
    logic        vld;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic        mis;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic c, input logic r, input logic g,
    input logic [31:0] d, input logic y,
    input logic v, input logic [31:0] t,
    input logic q, input logic [31:0] p,
    input logic l, input logic [31:0] i,
    input logic [31:0] ip, input logic m);
    vec_t x;
    x.chk = c; x.rst = r; x.gnt = g;
    x.rdata = d; x.rdy = y; x.rv = v;
    x.rpc = t; x.req = q; x.pc = p;
    x.vld = l; x.inst = i; x.ipc = ip;
    x.mis = m;
    return x;
  endfunction

  task automatic cmp(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h want=%h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic g, input logic [31:0] d,
                       input logic y, input logic v,
                       input logic [31:0] t);
    bus.imem_gnt       = g;
    bus.imem_rdata     = d;
    bus.inst_ready     = y;
    bus.redirect_valid = v;
    bus.redirect_pc    = t;
  endtask

  task automatic check_all(input int k, input vec_t e);
    cmp("imem_req", k, 32'(bus.imem_req), 32'(e.req));
    cmp("imem_addr", k, bus.imem_addr, e.pc);
    cmp("pc_out", k, bus.pc_out, e.pc);
    cmp("inst_valid", k, 32'(bus.inst_valid), 32'(e.vld));
    cmp("inst_out", k, bus.inst_out, e.inst);
    cmp("inst_pc", k, bus.inst_pc, e.ipc);
`ifdef FETCH_MISALIGN_TRAP_EN
    cmp("fetch_misaligned", k,
        32'(bus.fetch_misaligned), 32'(e.mis));
`endif
  endtask

  localparam logic [31:0] FC = 32'hFFFF_FFFC;
  localparam logic [31:0] LI = 32'h0050_0093;

  initial begin
    int n;
    bit seen;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // chk rst gnt rdata rdy rv rpc | req pc vld inst ipc mis
    vq.push_back(mk(0,0,0,32'h0,0,0,32'h0, 0,32'h0,0,32'h0,32'h0,0));
    vq.push_back(mk(1,0,1,32'h0,1,0,32'h0, 0,32'h0,0,32'h0,32'h0,0));
    vq.push_back(mk(1,1,1,32'hA0,1,0,32'h0, 0,32'h0,0,32'h0,32'h0,0));
    vq.push_back(mk(1,1,1,32'h11,1,0,32'h0, 1,32'h0,0,32'h0,32'h0,0));
    vq.push_back(mk(1,1,1,32'h22,1,0,32'h0, 0,32'h4,1,32'h11,32'h0,0));
    vq.push_back(mk(1,1,1,32'h22,1,0,32'h0, 1,32'h4,0,32'h11,32'h0,0));
    vq.push_back(mk(1,1,1,32'h33,1,0,32'h0, 0,32'h8,1,32'h22,32'h4,0));
    vq.push_back(mk(1,1,1,32'h33,1,0,32'h0, 1,32'h8,0,32'h22,32'h4,0));
    vq.push_back(mk(1,1,0,32'h0,1,0,32'h0, 0,32'hC,1,32'h33,32'h8,0));
    vq.push_back(mk(1,1,1,32'h44,1,0,32'h0, 1,32'hC,0,32'h33,32'h8,0));
    vq.push_back(mk(1,1,0,32'h0,1,0,32'h0, 0,32'h10,1,32'h44,32'hC,0));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(1,1,0,32'h55,0,0,32'h0,
                      1,32'h10,0,32'h44,32'hC,0));
    vq.push_back(mk(1,1,1,LI,0,0,32'h0, 1,32'h10,0,32'h44,32'hC,0));
    vq.push_back(mk(1,1,1,32'hAA,0,0,32'h0, 0,32'h14,1,LI,32'h10,0));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(1,1,0,32'h0,0,0,32'h0,
                      0,32'h14,1,LI,32'h10,0));
    vq.push_back(mk(1,1,0,32'h0,1,0,32'h0, 0,32'h14,1,LI,32'h10,0));
    vq.push_back(mk(1,1,1,32'h66,0,0,32'h0, 1,32'h14,0,LI,32'h10,0));
    vq.push_back(mk(1,1,0,32'h0,1,1,32'h40, 0,32'h18,1,32'h66,32'h14,0));
    vq.push_back(mk(1,1,1,32'h77,0,1,32'h200, 1,32'h40,0,32'h66,32'h14,0));
    vq.push_back(mk(1,1,0,32'h0,0,1,FC, 1,32'h200,0,32'h66,32'h14,0));
    vq.push_back(mk(1,1,1,32'h88,0,0,32'h0, 1,FC,0,32'h66,32'h14,0));
    vq.push_back(mk(1,1,0,32'h0,1,0,32'h0, 0,32'h0,1,32'h88,FC,0));
    vq.push_back(mk(1,1,0,32'h0,0,1,32'h102, 1,32'h0,0,32'h88,FC,0));
    vq.push_back(mk(1,1,0,32'h0,0,0,32'h0, !MIS,
                    MIS ? 32'h102 : 32'h100,0,32'h88,FC,MIS));
    vq.push_back(mk(1,1,1,32'hBB,0,1,32'h100, !MIS,
                    MIS ? 32'h102 : 32'h100,0,32'h88,FC,MIS));
    vq.push_back(mk(1,1,1,32'h99,0,0,32'h0, 1,32'h100,0,32'h88,FC,0));
    vq.push_back(mk(1,0,1,32'hCC,0,0,32'h0, 0,32'h104,1,32'h99,32'h100,0));
    vq.push_back(mk(1,1,0,32'h0,0,1,32'h300, 0,32'h0,0,32'h0,32'h0,0));
    vq.push_back(mk(1,1,0,32'h0,0,0,32'h0, 1,32'h300,0,32'h0,32'h0,0));

    foreach (vq[k]) begin
      @(negedge clk);
      reset = vq[k].rst;
      drive(vq[k].gnt, vq[k].rdata, vq[k].rdy,
            vq[k].rv, vq[k].rpc);
      #1;
      if (vq[k].chk) check_all(k, vq[k]);
    end

    // Grant from 0x300, bounded wait for valid.
    @(negedge clk);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 6) begin
      @(negedge clk);
      #1;
      seen = bus.inst_valid;
      n++;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL valid_timeout got=0 want=1");
    end
    cmp("seq_inst", 100, bus.inst_out, 32'hDEAD_BEEF);
    cmp("seq_ipc", 100, bus.inst_pc, 32'h300);
    cmp("seq_pc", 100, bus.pc_out, 32'h304);

    // Gnt while no request must not disturb the held word.
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    cmp("idle_gnt_inst", 101, bus.inst_out, 32'hDEAD_BEEF);
    cmp("idle_gnt_pc", 101, bus.pc_out, 32'h304);
    cmp("idle_gnt_req", 101, 32'(bus.imem_req), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns and sequences the program counter for the single-issue RISC-V core. Fetches instructions from the instruction memory over a req/gnt handshake and presents them to decode over a valid/ready handshake. Advances the PC by 4 on each completed fetch and applies redirects from execute (branch, jump or trap). It replaces the free-running PC register update with a controlled fetch loop.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
PC_STEP, 4, increment applied after each accepted fetch.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset (0 = reset); sampled on the rising edge of clk
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address; equals pc_out while imem_req=1
imem_gnt  input  1  memory accepts the request; imem_rdata is valid in the same cycle
imem_rdata  input  32  fetched instruction word
inst_valid  output  1  inst_out/inst_pc hold a valid instruction for decode
inst_ready  input  1  decode consumes the instruction this cycle
inst_out  output  32  buffered instruction
inst_pc  output  32  address of inst_out
redirect_valid  input  1  execute requests a PC change (taken branch, jump or trap)
redirect_pc  input  32  new PC target
pc_out  output  32  current fetch PC

Behaviour:
- Reset: the design samples reset=0 at a clock edge. It then sets pc_out=RESET_PC, state=IDLE, imem_req=0, inst_valid=0, inst_out=0 and inst_pc=0. Reset overrides every other input, including mid-handshake.
- States: IDLE, REQ, VALID.
- IDLE: imem_req=0. Always moves to REQ on the next cycle. This gives one bubble after reset release.
- REQ: imem_req=1 and imem_addr=pc_out. These hold stable until imem_gnt=1.
  - On gnt: inst_out<=imem_rdata, inst_pc<=pc_out, pc_out<=pc_out+PC_STEP, inst_valid<=1, move to VALID.
- VALID: imem_req=0 and inst_valid=1. Outputs hold stable while inst_ready=0.
  - On inst_ready=1: inst_valid<=0, move to REQ. The next request is issued the following cycle.
  - Peak throughput is 1 instruction per 2 cycles.
- Redirect: redirect_valid=1 has top priority in REQ and VALID.
  - Next cycle: pc_out<=redirect_pc, inst_valid<=0, state=REQ.
  - An imem_gnt in the same cycle as a redirect is ignored: its data is dropped and the PC is not incremented.
  - An inst_ready in the same cycle as a redirect is also ignored; the instruction is treated as flushed.
  - A redirect in IDLE is applied the same way, and the next state is REQ.
- Arithmetic: PC increment is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- imem_gnt while imem_req=0 is ignored.
- Without the optional feature, redirect_pc[1:0] is forced to 2'b00 when loaded.

Optional Feature:
Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit) and a fourth state, ERR.
  - A redirect with redirect_pc[1:0]!=0 loads pc_out unmodified and enters ERR.
  - In ERR: imem_req=0, inst_valid=0, fetch_misaligned=1. The block stays in ERR until a redirect arrives.
  - A following aligned redirect goes to REQ. A following misaligned redirect stays in ERR with the new pc_out.
  - Reset clears fetch_misaligned to 0.
- Not defined: no port and no ERR state; the low two bits are masked as described under Behaviour.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, REQ=2'd1, VALID=2'd2, ERR=2'd3);
  - the PC_STEP default;
  - a RESET_PC default constant, shared with the core top.
- One natural sub-module: fetch_inst_buffer, the one-entry inst_out/inst_pc holding register with valid/ready handling.
- Next-PC select and the FSM stay in the parent.

Test Plan:
- Reset low for 2 cycles, then released with RESET_PC=0 and gnt tied to 1. Required: imem_req=0 in the cycle after release; imem_addr=0x0, then 0x4, then 0x8; inst_pc follows the same values.
- imem_gnt held low for 3 cycles in REQ. Required: imem_req=1 and imem_addr unchanged (0x10) throughout; pc_out=0x14 only after gnt.
- inst_ready held low 4 cycles with inst_out=0x00500093. Required: inst_valid stays 1, inst_out and inst_pc stable, imem_req=0.
- Redirect to 0x200 in the same cycle as imem_gnt for 0x40. Required: the fetched word is dropped, inst_valid=0, and the next imem_addr=0x200.
- pc_out=0xFFFFFFFC with gnt. Required: inst_pc=0xFFFFFFFC and the next imem_addr=0x0.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102. Required: fetch_misaligned=1 and no imem_req until a redirect to 0x100, after which imem_addr=0x100. Without the macro, the same stimulus gives imem_addr=0x100 directly.
